// File: rtl/lcd_line_writer_pkg.sv
// lcd_line_writer_pkg
//   Shared constants, state encodings and small helpers for the LCD line
//   writer: HD44780 command bytes, ASCII codes used to format the line,
//   op_sel encodings and the value parked on the data bus when idle.
package lcd_line_writer_pkg;

  localparam logic [7:0] LCD_IDLE_BUS   = 8'hCC;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0E;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_DDRAM_0    = 8'h80;

  localparam logic [7:0] ASC_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASC_ALPHA_BASE = 8'h41;
  localparam logic [7:0] ASC_BLANK      = 8'h20;
  localparam logic [7:0] ASC_A          = 8'h41;
  localparam logic [7:0] ASC_B          = 8'h42;
  localparam logic [7:0] ASC_D          = 8'h44;
  localparam logic [7:0] ASC_N          = 8'h4E;
  localparam logic [7:0] ASC_O          = 8'h4F;
  localparam logic [7:0] ASC_R          = 8'h52;
  localparam logic [7:0] ASC_S          = 8'h53;
  localparam logic [7:0] ASC_U          = 8'h55;
  localparam logic [7:0] ASC_X          = 8'h58;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_WRITE
  } lw_state_e;

  typedef enum logic [2:0] {
    BT_IDLE,
    BT_SETUP,
    BT_PULSE,
    BT_HOLD,
    BT_WAIT
  } bt_phase_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASC_DIGIT_BASE + {4'd0, n};
    else           return ASC_ALPHA_BASE + {4'd0, n - 4'd10};
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY_MODE;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [1:0] pos);
    logic [23:0] s;
    case (op)
      OP_ADD:  s = {ASC_A, ASC_D, ASC_D};
      OP_SUB:  s = {ASC_S, ASC_U, ASC_B};
      OP_AND:  s = {ASC_A, ASC_N, ASC_D};
      OP_OR:   s = {ASC_O, ASC_R, ASC_BLANK};
      OP_XOR:  s = {ASC_X, ASC_O, ASC_R};
      default: s = {ASC_BLANK, ASC_BLANK, ASC_BLANK};
    endcase
    case (pos)
      2'd0:    return s[23:16];
      2'd1:    return s[15:8];
      default: return s[7:0];
    endcase
  endfunction

endpackage

// File: rtl/lcd_line_writer_if.sv
// lcd_line_writer_if
//   Request and LCD pin bundle of the line writer.
//   master: drives start/a_val/b_val/op_sel, observes the LCD pins and status.
//   slave : the line writer itself.
interface lcd_line_writer_if #(
  parameter int N_DIGITS = 4
);
  logic                  start;
  logic [4*N_DIGITS-1:0] a_val;
  logic [4*N_DIGITS-1:0] b_val;
  logic [2:0]            op_sel;
  logic [7:0]            lcd_db;
  logic                  lcd_rs;
  logic                  lcd_rw;
  logic                  lcd_e;
  logic                  ready;
  logic                  busy;

  modport master (
    output start, a_val, b_val, op_sel,
    input  lcd_db, lcd_rs, lcd_rw, lcd_e, ready, busy
  );

  modport slave (
    input  start, a_val, b_val, op_sel,
    output lcd_db, lcd_rs, lcd_rw, lcd_e, ready, busy
  );
endinterface

// File: rtl/lcd_line_writer_byte_timer.sv
// lcd_byte_timer
//   Times one LCD bus transfer: SETUP (1 cycle), PULSE (E high for
//   E_PULSE_CYC), HOLD (1 cycle), WAIT (CLEAR_WAIT_CYC after a Clear,
//   otherwise CMD_WAIT_CYC). The parent drives db/rs for the whole transfer.
//   Ports: clk, rst_n, i_go (launch; accepted in IDLE or on the last WAIT
//   cycle), i_is_clear (sampled with i_go), o_lcd_e, o_done (last WAIT cycle).
//
//   phase    | meaning
//   BT_IDLE  | no transfer in flight
//   BT_SETUP | data/rs settle, E low
//   BT_PULSE | E high
//   BT_HOLD  | E low, data held
//   BT_WAIT  | LCD execution time, data held
module lcd_byte_timer
  import lcd_line_writer_pkg::*;
#(
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_go,
  input  logic i_is_clear,
  output logic o_lcd_e,
  output logic o_done
);

  localparam int CNT_MAX = max_int(max_int(E_PULSE_CYC, CMD_WAIT_CYC), CLEAR_WAIT_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLEAR_WAIT_CYC - 1);

  bt_phase_e        r_phase, w_phase_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_is_clear, w_is_clear_next;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= BT_IDLE;
      r_cnt      <= '0;
      r_is_clear <= 1'b0;
    end else begin
      r_phase    <= w_phase_next;
      r_cnt      <= w_cnt_next;
      r_is_clear <= w_is_clear_next;
    end
  end

  always_comb begin
    w_phase_next    = r_phase;
    w_cnt_next      = r_cnt;
    w_is_clear_next = r_is_clear;
    case (r_phase)
      BT_IDLE: begin
        if (i_go) begin
          w_phase_next    = BT_SETUP;
          w_is_clear_next = i_is_clear;
        end
      end
      BT_SETUP: begin
        w_phase_next = BT_PULSE;
        w_cnt_next   = PULSE_LOAD;
      end
      BT_PULSE: begin
        if (w_cnt_zero) w_phase_next = BT_HOLD;
        else            w_cnt_next   = r_cnt - 1'b1;
      end
      BT_HOLD: begin
        w_phase_next = BT_WAIT;
        w_cnt_next   = r_is_clear ? CLR_LOAD : CMD_LOAD;
      end
      BT_WAIT: begin
        // back-to-back launch: next SETUP directly follows the last WAIT cycle
        if (w_cnt_zero) begin
          if (i_go) begin
            w_phase_next    = BT_SETUP;
            w_is_clear_next = i_is_clear;
          end else begin
            w_phase_next = BT_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_phase_next = BT_IDLE;
    endcase
  end

  always_comb begin
    o_lcd_e = (r_phase == BT_PULSE);
    o_done  = (r_phase == BT_WAIT) && w_cnt_zero;
  end

endmodule

// File: rtl/lcd_line_writer.sv
// lcd_line_writer
//   Powers up and initialises an HD44780 character LCD, then on request
//   writes one line "<A> <mnemonic> <B>" in hex. Operands and op code are
//   captured when the request is accepted.
//   Ports: clk, rst_n (async active-low), bus (slave modport):
//     start/a_val/b_val/op_sel in; lcd_db/lcd_rs/lcd_rw/lcd_e, ready, busy out.
//
//   state    | meaning
//   ST_PWRUP | waiting PWRUP_WAIT_CYC after reset release
//   ST_INIT  | issuing 38,0E,06,01
//   ST_IDLE  | ready for a line request
//   ST_WRITE | issuing address command and line characters
module lcd_line_writer
  import lcd_line_writer_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_line_writer_if.slave   bus
);

  localparam int N_CHARS = 2*N_DIGITS + 6;
  localparam int IDX_W   = $clog2(N_CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CHARS - 1);
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(3);
  localparam int DLY_MAX = max_int(max_int(CMD_WAIT_CYC, CLEAR_WAIT_CYC), PWRUP_WAIT_CYC);
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam logic [DLY_W-1:0] PWRUP_LOAD = DLY_W'(PWRUP_WAIT_CYC - 1);

  lw_state_e             r_state, w_state_next;
  logic [IDX_W-1:0]      r_idx, w_launch_idx;
  logic [7:0]            r_db, w_launch_db, w_line_db;
  logic                  r_rs, w_launch_rs, w_line_rs;
  logic [DLY_W-1:0]      r_dly;
  logic [4*N_DIGITS-1:0] r_a, r_b;
  logic [2:0]            r_op;
  logic                  w_go, w_snap, w_is_clear, w_done, w_lcd_e;

  lcd_byte_timer #(
    .E_PULSE_CYC    (E_PULSE_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_byte_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_go       (w_go),
    .i_is_clear (w_is_clear),
    .o_lcd_e    (w_lcd_e),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PWRUP;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_go         = 1'b0;
    w_snap       = 1'b0;
    w_launch_idx = r_idx;
    case (r_state)
      ST_PWRUP: begin
        if (r_dly == '0) begin
          w_state_next = ST_INIT;
          w_go         = 1'b1;
          w_launch_idx = '0;
        end
      end
      ST_INIT: begin
        if (w_done) begin
          if (r_idx == INIT_LAST) begin
            w_state_next = ST_IDLE;
          end else begin
            w_go         = 1'b1;
            w_launch_idx = r_idx + IDX_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_WRITE;
          w_go         = 1'b1;
          w_snap       = 1'b1;
          w_launch_idx = '0;
        end
      end
      ST_WRITE: begin
        if (w_done) begin
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_IDLE;
          end else begin
            w_go         = 1'b1;
            w_launch_idx = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_next = ST_PWRUP;
    endcase
  end

  // Line layout: [0]=addr cmd, [1..N]=A msd first, [N+1]=blank,
  // [N+2..N+4]=mnemonic, [N+5]=blank, [N+6..2N+5]=B msd first.
  // Index 0 needs no snapshot, so launching it in the request cycle is safe.
  always_comb begin
    int k;
    k         = int'(w_launch_idx);
    w_line_db = ASC_BLANK;
    w_line_rs = 1'b1;
    if (k == 0) begin
      w_line_db = CMD_DDRAM_0;
      w_line_rs = 1'b0;
    end else if (k <= N_DIGITS) begin
      w_line_db = hex_to_ascii(r_a[4*(N_DIGITS-k) +: 4]);
    end else if (k == N_DIGITS + 1) begin
      w_line_db = ASC_BLANK;
    end else if (k <= N_DIGITS + 4) begin
      w_line_db = mnemonic_char(r_op, 2'(k - N_DIGITS - 2));
    end else if (k == N_DIGITS + 5) begin
      w_line_db = ASC_BLANK;
    end else begin
      w_line_db = hex_to_ascii(r_b[4*(2*N_DIGITS+5-k) +: 4]);
    end
  end

  always_comb begin
    if (r_state == ST_PWRUP || r_state == ST_INIT) begin
      w_launch_db = init_cmd(w_launch_idx[1:0]);
      w_launch_rs = 1'b0;
    end else begin
      w_launch_db = w_line_db;
      w_launch_rs = w_line_rs;
    end
    w_is_clear = (w_launch_db == CMD_CLEAR) && !w_launch_rs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_db  <= LCD_IDLE_BUS;
      r_rs  <= 1'b0;
      r_dly <= PWRUP_LOAD;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
    end else begin
      if (r_state == ST_PWRUP && r_dly != '0) r_dly <= r_dly - 1'b1;
      if (w_go) begin
        r_idx <= w_launch_idx;
        r_db  <= w_launch_db;
        r_rs  <= w_launch_rs;
      end
      if (w_snap) begin
        r_a  <= bus.a_val;
        r_b  <= bus.b_val;
        r_op <= bus.op_sel;
      end
    end
  end

  always_comb begin
    bus.lcd_db = LCD_IDLE_BUS;
    bus.lcd_rs = 1'b0;
    if (r_state == ST_INIT || r_state == ST_WRITE) begin
      bus.lcd_db = r_db;
      bus.lcd_rs = r_rs;
    end
    bus.lcd_rw = 1'b0;
    bus.lcd_e  = w_lcd_e;
    bus.ready  = (r_state == ST_IDLE);
    bus.busy   = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_lcd_line_writer.sv
module tb_lcd_line_writer;

  localparam int E_P   = 2;
  localparam int CMD_W = 5;
  localparam int CLR_W = 20;
  localparam int PWR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_line_writer_if #(.N_DIGITS(4)) bus4();
  lcd_line_writer_if #(.N_DIGITS(1)) bus1();
  lcd_line_writer_if #(.N_DIGITS(8)) bus8();

  lcd_line_writer #(.N_DIGITS(4), .E_PULSE_CYC(E_P), .CMD_WAIT_CYC(CMD_W),
    .CLEAR_WAIT_CYC(CLR_W), .PWRUP_WAIT_CYC(PWR_W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  lcd_line_writer #(.N_DIGITS(1), .E_PULSE_CYC(E_P), .CMD_WAIT_CYC(CMD_W),
    .CLEAR_WAIT_CYC(CLR_W), .PWRUP_WAIT_CYC(PWR_W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  lcd_line_writer #(.N_DIGITS(8), .E_PULSE_CYC(E_P), .CMD_WAIT_CYC(CMD_W),
    .CLEAR_WAIT_CYC(CLR_W), .PWRUP_WAIT_CYC(PWR_W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0] db;
    logic       rs;
    logic       e;
    logic       rdy;
  } exp_t;
  typedef logic [8:0] bq_t[$];

  exp_t q4[$];

  function automatic logic [7:0] m_hex(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic logic [7:0] m_mn(input int op, input int pos);
    string s;
    case (op)
      0: s = "ADD";
      1: s = "SUB";
      2: s = "AND";
      3: s = "OR ";
      4: s = "XOR";
      default: s = "   ";
    endcase
    return 8'(s[pos]);
  endfunction

  task automatic build_line(input int n, input logic [31:0] a, input logic [31:0] b,
                            input int op, output bq_t q);
    q.delete();
    q.push_back({1'b0, 8'h80});
    for (int i = n - 1; i >= 0; i--) q.push_back({1'b1, m_hex(int'((a >> (4*i)) & 32'hF))});
    q.push_back({1'b1, 8'h20});
    for (int i = 0; i < 3; i++) q.push_back({1'b1, m_mn(op, i)});
    q.push_back({1'b1, 8'h20});
    for (int i = n - 1; i >= 0; i--) q.push_back({1'b1, m_hex(int'((b >> (4*i)) & 32'hF))});
  endtask

  task automatic push_cyc(input logic [7:0] db, input logic rs, input logic e);
    exp_t t;
    t.db = db; t.rs = rs; t.e = e; t.rdy = 1'b0;
    q4.push_back(t);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rs);
    int w;
    w = (b == 8'h01 && !rs) ? CLR_W : CMD_W;
    push_cyc(b, rs, 1'b0);
    repeat (E_P) push_cyc(b, rs, 1'b1);
    push_cyc(b, rs, 1'b0);
    repeat (w) push_cyc(b, rs, 1'b0);
  endtask

  // Called just after reset release; the first sampled cycle is cycle 1.
  task automatic push_pwrup_init();
    repeat (PWR_W - 1) push_cyc(8'hCC, 1'b0, 1'b0);
    push_byte(8'h38, 1'b0);
    push_byte(8'h0E, 1'b0);
    push_byte(8'h06, 1'b0);
    push_byte(8'h01, 1'b0);
  endtask

  task automatic push_line(input logic [31:0] a, input logic [31:0] b, input int op);
    bq_t q;
    build_line(4, a, b, op, q);
    foreach (q[i]) push_byte(q[i][7:0], q[i][8]);
  endtask

  // every-cycle compare of dut4 pins against the model
  always @(negedge clk) begin : cmp4
    exp_t ex;
    if (!rst_n) begin
      ex.db = 8'hCC; ex.rs = 1'b0; ex.e = 1'b0; ex.rdy = 1'b0;
    end else if (q4.size() > 0) begin
      ex = q4.pop_front();
    end else begin
      ex.db = 8'hCC; ex.rs = 1'b0; ex.e = 1'b0; ex.rdy = 1'b1;
    end
    chk("wave4 {db,rs,e,ready,busy,rw}",
        {bus4.lcd_db, bus4.lcd_rs, bus4.lcd_e, bus4.ready, bus4.busy, bus4.lcd_rw},
        {ex.db, ex.rs, ex.e, ex.rdy, ~ex.rdy, 1'b0});
  end

  // byte capture on each E rising edge
  logic [8:0] cap4[$], cap1[$], cap8[$];
  logic p4 = 1'b0, p1 = 1'b0, p8 = 1'b0;
  always @(negedge clk) begin
    if (bus4.lcd_e && !p4) cap4.push_back({bus4.lcd_rs, bus4.lcd_db});
    if (bus1.lcd_e && !p1) cap1.push_back({bus1.lcd_rs, bus1.lcd_db});
    if (bus8.lcd_e && !p8) cap8.push_back({bus8.lcd_rs, bus8.lcd_db});
    p4 = bus4.lcd_e;
    p1 = bus1.lcd_e;
    p8 = bus8.lcd_e;
  end

  logic [8:0] lit_init [4]  = '{9'h038, 9'h00E, 9'h006, 9'h001};
  logic [8:0] lit_l1   [14] = '{9'h080, 9'h131, 9'h132, 9'h141, 9'h146, 9'h120, 9'h158,
                                9'h14F, 9'h152, 9'h120, 9'h130, 9'h130, 9'h130, 9'h139};
  logic [8:0] lit_n1   [8]  = '{9'h080, 9'h141, 9'h120, 9'h141, 9'h144, 9'h144, 9'h120, 9'h137};

  task automatic wait_ready(input int budget, input string name);
    int n;
    n = 0;
    while (!(bus4.ready && bus1.ready && bus8.ready) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, {bus4.ready, bus1.ready, bus8.ready}, 3'b111);
  endtask

  task automatic check_init_caps(input string name);
    chk({name, "_count"}, cap4.size(), 4);
    for (int i = 0; i < 4; i++) chk({name, "_byte"}, cap4[i], lit_init[i]);
  endtask

  task automatic check_line_caps(input int n, input bq_t act, input bq_t exp, input string name);
    int nd;
    nd = 0;
    foreach (act[i]) if (act[i][8]) nd++;
    chk({name, "_data_count"}, nd, 2*n + 5);
    chk({name, "_count"}, act.size(), exp.size());
    foreach (exp[i]) chk({name, "_byte"}, act[i], exp[i]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bq_t eq;
    int n;
    bus4.start = 1'b0; bus4.a_val = '0; bus4.b_val = '0; bus4.op_sel = '0;
    bus1.start = 1'b0; bus1.a_val = '0; bus1.b_val = '0; bus1.op_sel = '0;
    bus8.start = 1'b0; bus8.a_val = '0; bus8.b_val = '0; bus8.op_sel = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_db", bus4.lcd_db, 8'hCC);
    chk("rst_busy_ready", {bus4.busy, bus4.ready}, 2'b10);

    // power-up and init
    rst_n = 1'b1;
    push_pwrup_init();
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++;
      #1;
      if (bus4.lcd_e) break;
    end
    chk("first_e_rise_cycles", n, 11);
    wait_ready(400, "init_ready");
    check_init_caps("init");

    // line 1 on dut4 plus digit sweep on dut1/dut8
    cap4.delete(); cap1.delete(); cap8.delete();
    @(negedge clk); #1;
    bus4.a_val = 16'h12AF; bus4.b_val = 16'h0009; bus4.op_sel = 3'd4; bus4.start = 1'b1;
    push_line(32'h12AF, 32'h0009, 4);
    bus1.a_val = 4'hA; bus1.b_val = 4'h7; bus1.op_sel = 3'd0; bus1.start = 1'b1;
    bus8.a_val = 32'h0123ABCD; bus8.b_val = 32'hFEDC9876; bus8.op_sel = 3'd1; bus8.start = 1'b1;
    @(negedge clk); #1;
    chk("start_drops_ready", {bus4.ready, bus1.ready, bus8.ready}, 3'b000);
    bus4.start = 1'b0; bus1.start = 1'b0; bus8.start = 1'b0;
    wait_ready(400, "line1_ready");
    chk("l1_count", cap4.size(), 14);
    for (int i = 0; i < 14; i++) chk("l1_byte", cap4[i], lit_l1[i]);
    build_line(1, 32'hA, 32'h7, 0, eq);
    check_line_caps(1, cap1, eq, "n1");
    for (int i = 0; i < 8; i++) chk("n1_lit", cap1[i], lit_n1[i]);
    build_line(8, 32'h0123ABCD, 32'hFEDC9876, 1, eq);
    check_line_caps(8, cap8, eq, "n8");
    chk("n8_first_digit", cap8[1], 9'h130);
    chk("n8_last_digit", cap8[21], 9'h136);

    // line 2: op OR, inputs churn every cycle, extra start while busy
    cap4.delete();
    @(negedge clk); #1;
    bus4.a_val = 16'h3C5D; bus4.b_val = 16'h0100; bus4.op_sel = 3'd3; bus4.start = 1'b1;
    push_line(32'h3C5D, 32'h0100, 3);
    n = 0;
    do begin
      @(negedge clk); #1;
      bus4.start  = (n == 20);
      bus4.a_val  = 16'($urandom);
      bus4.b_val  = 16'($urandom);
      bus4.op_sel = 3'($urandom_range(0, 7));
      n++;
    end while (!bus4.ready && n < 400);
    bus4.start = 1'b0;
    chk("line2_ready", bus4.ready, 1'b1);
    repeat (30) @(negedge clk);
    #1;
    chk("l2_count_no_second_line", cap4.size(), 14);
    chk("l2_a_msd", cap4[1], 9'h133);
    chk("l2_a_2", cap4[2], 9'h143);
    chk("l2_mn0", cap4[6], 9'h14F);
    chk("l2_mn1", cap4[7], 9'h152);
    chk("l2_mn2", cap4[8], 9'h120);
    chk("l2_b_3", cap4[11], 9'h131);

    // line 3: blank mnemonic
    cap4.delete();
    bus4.a_val = 16'h0000; bus4.b_val = 16'hFFFF; bus4.op_sel = 3'd6; bus4.start = 1'b1;
    push_line(32'h0000, 32'hFFFF, 6);
    @(negedge clk); #1;
    bus4.start = 1'b0;
    wait_ready(400, "line3_ready");
    chk("l3_mn0", cap4[6], 9'h120);
    chk("l3_mn1", cap4[7], 9'h120);
    chk("l3_mn2", cap4[8], 9'h120);
    chk("l3_b_msd", cap4[10], 9'h146);

    // line 4: reset during the 5th data byte
    cap4.delete();
    bus4.a_val = 16'h4567; bus4.b_val = 16'h89AB; bus4.op_sel = 3'd2; bus4.start = 1'b1;
    push_line(32'h4567, 32'h89AB, 2);
    @(negedge clk); #1;
    bus4.start = 1'b0;
    n = 0;
    while (cap4.size() < 6 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("l4_reached_5th_data", cap4.size(), 6);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q4.delete();
    #1;
    chk("mr_db", bus4.lcd_db, 8'hCC);
    chk("mr_rs_e_rw", {bus4.lcd_rs, bus4.lcd_e, bus4.lcd_rw}, 3'b000);
    chk("mr_busy_ready", {bus4.busy, bus4.ready}, 2'b10);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    cap4.delete();
    push_pwrup_init();
    wait_ready(400, "reinit_ready");
    check_init_caps("reinit");
    repeat (5) @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_line_writer.md
Name: lcd_line_writer

Overview:
Parametrised successor to the combinational LCD byte-select datapath. Sequences the HD44780 power-up/init command set with programmable timing, then on request writes one formatted line: operand A, operation mnemonic, operand B. Drives the character-LCD pins directly. Operands and op code are snapshotted when the request is accepted, so the calculator core may change them mid-write without corrupting the line.

Parameters:
N_DIGITS, 4, hex digits per operand (1..8)
E_PULSE_CYC, 12, cycles E is held high per byte (>=1)
CMD_WAIT_CYC, 2000, cycles after E falls before the next byte, normal command/data
CLEAR_WAIT_CYC, 82000, cycles after E falls following the Clear command
PWRUP_WAIT_CYC, 750000, cycles idle after reset release before the first byte

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a line update; accepted only when ready=1
a_val  in  4*N_DIGITS  operand A, nibble [3:0] = least significant digit
b_val  in  4*N_DIGITS  operand B, same layout
op_sel  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5..7 blank
lcd_db  out  8  LCD data bus
lcd_rs  out  1  0 command, 1 character data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
ready  out  1  1 in IDLE: init done, no write in progress
busy  out  1  ~ready

Behaviour:
- Reset (async assert, sync release): lcd_db=8'hCC, lcd_rs=0, lcd_rw=0, lcd_e=0, ready=0, busy=1; FSM=PWRUP; snapshot registers cleared.
- FSM: PWRUP -> INIT -> IDLE -> WRITE -> IDLE.
- PWRUP: count PWRUP_WAIT_CYC cycles, then INIT.
- INIT byte order, all with rs=0: 8'h38 function set, 8'h0E display on, 8'h06 entry mode, 8'h01 clear. After the last wait: IDLE, ready=1.
- Byte cycle, identical for commands and data:
  - SETUP: 1 cycle, lcd_db/lcd_rs driven, lcd_e=0.
  - PULSE: E_PULSE_CYC cycles, lcd_e=1, db/rs held.
  - HOLD: 1 cycle, lcd_e=0, db/rs held.
  - WAIT: CLEAR_WAIT_CYC after 8'h01, otherwise CMD_WAIT_CYC; db/rs held.
  - Total per byte = 2 + E_PULSE_CYC + wait.
- IDLE: lcd_db=8'hCC, rs=0, e=0.
  - start=1 latches a_val, b_val and op_sel into snapshot registers in that cycle, drops ready next cycle, and enters WRITE.
  - start while not ready is ignored; it is not queued.
- WRITE byte order:
  - 8'h80, rs=0 (DDRAM address 0).
  - N_DIGITS A characters, most significant digit first, rs=1.
  - 8'h20 space.
  - 3 mnemonic characters: ADD, SUB, AND, "OR ", XOR, or "   " for 5..7.
  - 8'h20 space.
  - N_DIGITS B characters.
  - Total data bytes = 2*N_DIGITS+5.
  - Return to IDLE after the final wait; ready rises that cycle.
- Hex to ASCII per nibble: 0..9 -> 8'h30+n; A..F -> 8'h41+(n-10).
- Character index counter width = clog2(2*N_DIGITS+6). Delay counter width = clog2 of the largest wait parameter.
- Only one byte is in flight at a time; e never pulses during WAIT.
- Reset mid-operation: immediate return to reset values and the full PWRUP/INIT sequence is redone; a partial line is abandoned.

Decomposition:
- Shared package/defines: ASCII constants (0x30 base, 0x41, blank 0x20, mnemonic letters), LCD command constants (0x38, 0x0E, 0x06, 0x01, 0x80), op_sel encodings, idle bus value 8'hCC.
- One natural sub-module: lcd_byte_timer, which implements the SETUP/PULSE/HOLD/WAIT cycle. Interface: go, is_clear, lcd_e, done.
- Parent holds the PWRUP/INIT/IDLE/WRITE FSM, the snapshots and the character mux.

Test Plan:
- All tests use N_DIGITS=4, E_PULSE_CYC=2, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=20, PWRUP_WAIT_CYC=10.
- Reset release -> first e rise after 11 cycles. INIT bytes 38,0E,06,01 with rs=0 and e high 2 cycles each; gap to next SETUP is 5 cycles (20 after 01). ready=1 after clear completes.
- a_val=16'h12AF, b_val=16'h0009, op_sel=4, start pulse -> bytes 80 (rs=0), then "12AF XOR 0009" = 31 32 41 46 20 58 4F 52 20 30 30 30 39 (rs=1); ready returns afterward.
- op_sel=3 and op_sel=6 -> mnemonic bytes 4F 52 20 and 20 20 20 respectively.
- Change a_val, b_val and op_sel every cycle during WRITE -> output matches the values latched at start. A start pulse while busy -> no second line.
- Assert rst_n low during the 5th data byte -> outputs take reset values in the same cycle (async). The sequence restarts with PWRUP, and INIT bytes are reissued.
- Parameter sweep N_DIGITS=1 and 8 -> 7 and 21 data bytes respectively, with correct digit order.
